lfsr_7b_checker: RTL and testbench

Receive-side partner of the 7-bit BIST pattern generator. It takes the generator's serial output stream, one bit per accepted cycle, and self-seeds from the first 7 bits. It then predicts every following bit with the same recurrence, s[n+7] = s[n] ^ s[n+1], and reports lock, per-bit mismatches and saturating error and bit counts. It sits at the far end of a scan/BIST path, behind the circuit under test.

---
 rtl/lfsr_7b_checker.sv | 97 +++++++++
 tb/tb_lfsr_7b_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_7b_checker.sv
// Receive-side checker for the 7-bit BIST generator (s[n+7] = s[n] ^ s[n+1]).
// Self-seeds from 7 received bits, then tracks lock, mismatches and saturating counts.
module lfsr_7b_checker #(
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {
    SEED,
    CHECK
  } state_t;

  localparam logic [3:0] THRESH = ERR_THRESH[3:0];

  state_t     state;
  logic [2:0] fill;
  logic [6:0] w;
  logic [3:0] miss_run;

  logic [6:0] w_next;
  logic       pred;
  logic       mismatch;
  logic [3:0] miss_next;

  // The received bit is always shifted in (never pred), so the window resyncs itself.
  always_comb begin
    w_next    = {din, w[6:1]};
    pred      = w[0] ^ w[1];
    mismatch  = din ^ pred;
    miss_next = miss_run + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEED;
      fill      <= '0;
      w         <= '0;
      miss_run  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (valid_in) begin
        w <= w_next;
        case (state)
          SEED: begin
            if (fill == 3'd6) begin
              fill <= '0;
              // An all-zero window is the generator lock-up state; refill instead.
              if (|w_next) begin
                state  <= CHECK;
                locked <= 1'b1;
              end
            end else begin
              fill <= fill + 3'd1;
            end
          end
          CHECK: begin
            if (bit_count != '1) bit_count <= bit_count + CNT_W'(1);
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              if (miss_next == THRESH) begin
                state    <= SEED;
                fill     <= '0;
                miss_run <= '0;
                locked   <= 1'b0;
              end else begin
                miss_run <= miss_next;
              end
            end else begin
              miss_run <= '0;
            end
          end
        endcase
      end
      // Clear overrides any increment made above in the same cycle.
      if (clear_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_7b_checker.sv
// Scoreboard bench for lfsr_7b_checker: a stream-level reference model predicts outputs,
// a monitor compares them every cycle for a 16-bit and a 4-bit counter instance.
module tb_lfsr_7b_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        din = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked16, ep16, locked4, ep4;
  logic [15:0] err16, bit16;
  logic [3:0]  err4, bit4;

  always #5 clk = ~clk;

  lfsr_7b_checker #(.ERR_THRESH(3), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .din(din), .clear_cnt(clear_cnt),
    .locked(locked16), .err_pulse(ep16), .err_count(err16), .bit_count(bit16)
  );

  lfsr_7b_checker #(.ERR_THRESH(3), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .din(din), .clear_cnt(clear_cnt),
    .locked(locked4), .err_pulse(ep4), .err_count(err4), .bit_count(bit4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Generator stream from seed 8: x[0] per enabled cycle.
  bit gen[1024];
  int gidx = 0;

  // Reference model: counts stream positions rather than mirroring registers.
  typedef struct {
    bit locked;
    bit ep;
    int e16, b16, e4, b4;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  bit   m_seeding = 1'b1;
  int   m_nseed = 0, m_run = 0;
  bit   m_locked = 1'b0, m_ep = 1'b0;
  int   m_e16 = 0, m_b16 = 0, m_e4 = 0, m_b4 = 0;

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_step(input bit v, input bit d, input bit c, input bit r);
    bit pred;
    bit nz;
    if (!r) begin
      hist.delete();
      m_seeding = 1'b1; m_nseed = 0; m_run = 0;
      m_locked = 1'b0; m_ep = 1'b0;
      m_e16 = 0; m_b16 = 0; m_e4 = 0; m_b4 = 0;
      return;
    end
    m_ep = 1'b0;
    if (v) begin
      if (m_seeding) begin
        hist.push_back(d);
        if (hist.size() > 7) void'(hist.pop_front());
        m_nseed++;
        if (m_nseed == 7) begin
          m_nseed = 0;
          nz = 1'b0;
          foreach (hist[i]) nz |= hist[i];
          if (nz) begin
            m_seeding = 1'b0;
            m_locked  = 1'b1;
          end
        end
      end else begin
        pred = hist[0] ^ hist[1];
        hist.push_back(d);
        if (hist.size() > 7) void'(hist.pop_front());
        m_b16 = sat(m_b16, 65535);
        m_b4  = sat(m_b4, 15);
        if (d != pred) begin
          m_ep  = 1'b1;
          m_e16 = sat(m_e16, 65535);
          m_e4  = sat(m_e4, 15);
          m_run++;
          if (m_run == 3) begin
            m_seeding = 1'b1; m_nseed = 0; m_run = 0; m_locked = 1'b0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    if (c) begin
      m_e16 = 0; m_b16 = 0; m_e4 = 0; m_b4 = 0;
    end
  endtask

  task automatic drive(input bit v, input bit d, input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    valid_in  = v;
    din       = d;
    clear_cnt = c;
    reset     = r;
    model_step(v, d, c, r);
    e.locked = m_locked; e.ep = m_ep;
    e.e16 = m_e16; e.b16 = m_b16; e.e4 = m_e4; e.b4 = m_b4;
    sb.push_back(e);
  endtask

  // idle_pct: chance (percent) of inserting a valid_in=0 cycle before each bit.
  task automatic stream(input int n, input int flo, input int fhi, input int clr_at,
                        input int idle_pct);
    int sent = 0;
    while (sent < n) begin
      if (idle_pct > 0 && int'($urandom_range(99)) < idle_pct) begin
        drive(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1);
      end else begin
        drive(1'b1, gen[gidx] ^ (gidx >= flo && gidx <= fhi), gidx == clr_at, 1'b1);
        gidx++;
        sent++;
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    gidx = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle's outputs are checked against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked16", int'(locked16), int'(e.locked));
        chk("err_pulse16", int'(ep16), int'(e.ep));
        chk("err_count16", int'(err16), e.e16);
        chk("bit_count16", int'(bit16), e.b16);
        chk("locked4", int'(locked4), int'(e.locked));
        chk("err_pulse4", int'(ep4), int'(e.ep));
        chk("err_count4", int'(err4), e.e4);
        chk("bit_count4", int'(bit4), e.b4);
      end
    end
  end

  initial begin
    bit [6:0] x;
    x = 7'd8;
    for (int i = 0; i < 1024; i++) begin
      gen[i] = x[0];
      x = {x[0] ^ x[1], x[6:1]};
    end

    // Clean stream from reset.
    do_reset();
    stream(200, -1, -1, -1, 0);
    settle();
    chk("clean_locked", int'(locked16), 1);
    chk("clean_err", int'(err16), 0);
    chk("clean_bits", int'(bit16), 193);

    // Single flipped bit: three mismatches, lock kept.
    do_reset();
    stream(100, 50, 50, -1, 0);
    settle();
    chk("flip_err", int'(err16), 3);
    chk("flip_locked", int'(locked16), 1);

    // Burst of three drops lock; lock returns exactly 7 valid bits later.
    stream(3, gidx, gidx + 2, -1, 0);
    settle();
    chk("burst_unlock", int'(locked16), 0);
    stream(6, -1, -1, -1, 0);
    settle();
    chk("reseed_6", int'(locked16), 0);
    stream(1, -1, -1, -1, 0);
    settle();
    chk("reseed_7", int'(locked16), 1);
    stream(30, -1, -1, -1, 0);

    // All-zero seed window stays in SEED.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("zero_seed_locked", int'(locked16), 0);
    stream(7, -1, -1, -1, 0);
    settle();
    chk("zero_then_lock", int'(locked16), 1);
    stream(20, -1, -1, -1, 0);

    // Randomly gapped valid_in: same result as the continuous stream.
    do_reset();
    stream(200, -1, -1, -1, 50);
    settle();
    chk("gapped_bits", int'(bit16), 193);
    chk("gapped_err", int'(err16), 0);

    // Isolated flips saturate the 4-bit counters; clear coincident with a mismatch.
    do_reset();
    stream(20, -1, -1, -1, 0);
    for (int i = 0; i < 20; i++) stream(10, gidx + 3, gidx + 3, -1, 0);
    settle();
    chk("sat_err4", int'(err4), 15);
    stream(4, gidx + 3, gidx + 3, gidx + 3, 0);
    settle();
    chk("clr_err16", int'(err16), 0);
    chk("clr_pulse", int'(ep16), 1);
    stream(10, -1, -1, -1, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("midrst_locked", int'(locked16), 0);
    chk("midrst_bits", int'(bit16), 0);

    // Randomised stream with sporadic flips, gaps and clears.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(99) < 30) begin
        drive(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1);
      end else begin
        drive(1'b1, gen[gidx] ^ ($urandom_range(99) < 8), $urandom_range(99) < 4, 1'b1);
        gidx++;
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
